// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Purpose  : Multiplexed 7-segment scan controller with a shadow/active entry
//            buffer, PWM brightness, guard band and leading-zero suppression.
// Revision : 1.0
// ============================================================================
module seg7_scan_ctrl #(
  parameter int N_DIGITS    = 8,
  parameter int DIV_LOG2    = 14,
  parameter int BRIGHT_W    = 3,
  parameter int GUARD       = 4,
  parameter int EN_ACT_LOW  = 1,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wr_stb,
  input  logic [3:0]          i_wr_addr,
  input  logic [7:0]          i_wr_data,
  input  logic                i_commit,
  input  logic [BRIGHT_W-1:0] i_bright,
  input  logic                i_lz_sup,
  output logic                o_commit_pend,
  output logic                o_frame,
  output logic [6:0]          o_seg,
  output logic                o_dp,
  output logic [N_DIGITS-1:0] o_en
);

  localparam int                  c_DIG_W    = $clog2(N_DIGITS);
  localparam logic [c_DIG_W-1:0]  c_LAST_DIG = c_DIG_W'(N_DIGITS - 1);
  localparam logic [DIV_LOG2-1:0] c_GUARD    = DIV_LOG2'(GUARD);
  localparam logic [7:0]          c_BLANK    = 8'h20;
  localparam logic                c_EN_INV   = (EN_ACT_LOW != 0);
  localparam logic                c_SEG_INV  = (SEG_ACT_LOW != 0);

  logic [DIV_LOG2-1:0] slot_cnt_q, slot_cnt_d;
  logic [c_DIG_W-1:0]  dig_q, dig_d;
  logic [7:0]          shadow_q [N_DIGITS];
  logic [7:0]          shadow_d [N_DIGITS];
  logic [7:0]          active_q [N_DIGITS];
  logic [7:0]          active_d [N_DIGITS];
  logic                pend_q, pend_d;
  logic                frame_q, frame_d;
  logic [N_DIGITS-1:0] en_q, en_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  logic                w_slot_wrap;
  logic                w_boundary;
  logic                w_gate;
  logic [N_DIGITS-1:0] w_dark;
  logic                w_above;
  logic [7:0]          w_cur;

  function automatic logic [6:0] f_hex2seg(input logic [3:0] v);
    case (v)
      4'h0:    f_hex2seg = 7'h7E;
      4'h1:    f_hex2seg = 7'h30;
      4'h2:    f_hex2seg = 7'h6D;
      4'h3:    f_hex2seg = 7'h79;
      4'h4:    f_hex2seg = 7'h33;
      4'h5:    f_hex2seg = 7'h5B;
      4'h6:    f_hex2seg = 7'h5F;
      4'h7:    f_hex2seg = 7'h70;
      4'h8:    f_hex2seg = 7'h7F;
      4'h9:    f_hex2seg = 7'h7B;
      4'hA:    f_hex2seg = 7'h77;
      4'hB:    f_hex2seg = 7'h1F;
      4'hC:    f_hex2seg = 7'h4E;
      4'hD:    f_hex2seg = 7'h3D;
      4'hE:    f_hex2seg = 7'h4F;
      default: f_hex2seg = 7'h47;
    endcase
  endfunction

  assign w_slot_wrap = &slot_cnt_q;
  assign w_boundary  = w_slot_wrap && (dig_q == c_LAST_DIG);
  assign w_gate      = (slot_cnt_q >= c_GUARD) &&
                       (slot_cnt_q[DIV_LOG2-1 -: BRIGHT_W] < i_bright);
  assign w_cur       = active_q[dig_q];

  // Suppression ripples downward from the most significant digit.
  always_comb begin
    w_above = 1'b1;
    w_dark  = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      w_dark[k] = active_q[k][5] |
                  (i_lz_sup & (k != 0) & (active_q[k][3:0] == 4'h0) &
                   ~active_q[k][4] & w_above);
      w_above   = w_above & w_dark[k];
    end
  end

  always_comb begin
    slot_cnt_d = slot_cnt_q + DIV_LOG2'(1);
    dig_d      = dig_q;
    if (w_slot_wrap) begin
      dig_d = (dig_q == c_LAST_DIG) ? '0 : dig_q + c_DIG_W'(1);
    end
    frame_d  = w_boundary;
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    // Copy takes the pre-write shadow; a coincident write only reaches shadow.
    if (w_boundary && pend_q) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end else if (i_commit && !pend_q) begin
      pend_d = 1'b1;
    end
    if (i_wr_stb) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        if (i_wr_addr == 4'(k)) shadow_d[k] = i_wr_data;
      end
    end
  end

  always_comb begin
    en_d  = '0;
    seg_d = '0;
    dp_d  = 1'b0;
    if (w_gate) begin
      en_d[dig_q] = 1'b1;
      if (!w_dark[dig_q]) begin
        seg_d = f_hex2seg(w_cur[3:0]);
        dp_d  = w_cur[4];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_cnt_q <= '0;
      dig_q      <= '0;
      shadow_q   <= '{default: c_BLANK};
      active_q   <= '{default: c_BLANK};
      pend_q     <= 1'b0;
      frame_q    <= 1'b0;
      en_q       <= '0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      dig_q      <= dig_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      frame_q    <= frame_d;
      en_q       <= en_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign o_commit_pend = pend_q;
  assign o_frame       = frame_q;
  assign o_en          = en_q ^ {N_DIGITS{c_EN_INV}};
  assign o_seg         = seg_q ^ {7{c_SEG_INV}};
  assign o_dp          = dp_q ^ c_SEG_INV;

endmodule
`default_nettype wire
